cpu0_uart_tx: RTL

//  Memory-mapped serial console on the cpu0 memory bus, next to memory0. Decodes
//  CPU stores to the I/O window and queues their bytes in a FIFO. Drains the FIFO

---
 rtl/cpu0_uart_tx.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu0_uart_tx.sv
// Memory-mapped 8N1 serial console for the cpu0 bus: store decode, word packing,
// byte FIFO, serial transmitter, status/control registers and drained interrupt.
module cpu0_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0008_0000,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rw,
    input  logic [1:0]  m_size,
    input  logic [31:0] abus,
    input  logic [31:0] dbus_in,
    output logic [31:0] dbus_out,
    output logic        tx,
    output logic        tx_strobe,
    output logic [7:0]  tx_byte,
    output logic        irq
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd8;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] FIFO_FULL_CNT = PW'(FIFO_DEPTH);

    typedef enum logic {
        P_IDLE,
        P_PACK
    } pack_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_t;

    // Bus decode
    logic        en_q;
    logic        acc;
    logic        sel_data;
    logic        sel_stat;
    logic        sel_ctrl;
    logic        wr_data;
    logic        wr_ctrl;
    logic        stat_rd_acc;
    logic        rd_sel;
    logic [31:0] rdata;

    // Pack FSM
    pack_state_t p_state;
    pack_state_t p_next;
    logic [31:0] pack_buf;
    logic [31:0] pack_buf_n;
    logic [1:0]  pack_idx;
    logic [1:0]  pack_idx_n;
    logic [1:0]  pack_last;
    logic [1:0]  pack_last_n;
    logic [7:0]  pack_cur;
    logic        pack_drop;
    logic        push;
    logic [7:0]  push_byte;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          pop;
    logic [7:0]    head;

    // Transmitter
    tx_state_t t_state;
    tx_state_t t_next;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_n;
    logic          baud_end;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic [7:0]    cur_byte;
    logic [7:0]    cur_byte_n;
    logic          tx_n;
    logic          strobe_n;

    // Status/control
    logic ovf;
    logic ovf_set;
    logic irq_en;
    logic idle;

    assign acc         = en & ~en_q;
    assign sel_data    = (abus == BASE_ADDR);
    assign sel_stat    = (abus == STAT_ADDR);
    assign sel_ctrl    = (abus == CTRL_ADDR);
    assign wr_data     = acc & ~rw & sel_data;
    assign wr_ctrl     = acc & ~rw & sel_ctrl;
    assign stat_rd_acc = acc & rw & sel_stat;
    assign rd_sel      = en & rw & (sel_data | sel_stat | sel_ctrl);

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == FIFO_FULL_CNT);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push & (~full | pop);
    assign ovf_set = pack_drop | (push & full & ~pop);
    assign idle    = empty & (t_state == T_IDLE) & (p_state == P_IDLE);

    assign pack_cur = pack_buf[{pack_idx, 3'b000} +: 8];
    assign baud_end = (baud == BAUD_LAST);

    // Read mux; the bus is released whenever no register of this block is read
    always_comb begin
        rdata = 32'h0;
        if (sel_stat) begin
            rdata = {16'h0, 8'(count), 4'h0, irq_en, ovf, full, idle};
        end else if (sel_ctrl) begin
            rdata = {31'h0, irq_en};
        end
    end

    assign dbus_out = rd_sel ? rdata : 32'hzzzz_zzzz;

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    // Pack FSM: byte stores go straight to the FIFO, wider stores unpack LSB-first
    always_ff @(posedge clock) begin
        if (reset) begin
            p_state   <= P_IDLE;
            pack_buf  <= 32'h0;
            pack_idx  <= 2'd0;
            pack_last <= 2'd0;
        end else begin
            p_state   <= p_next;
            pack_buf  <= pack_buf_n;
            pack_idx  <= pack_idx_n;
            pack_last <= pack_last_n;
        end
    end

    always_comb begin
        p_next      = p_state;
        pack_buf_n  = pack_buf;
        pack_idx_n  = pack_idx;
        pack_last_n = pack_last;
        pack_drop   = 1'b0;
        push        = 1'b0;
        push_byte   = 8'h00;
        case (p_state)
            P_IDLE: begin
                if (wr_data) begin
                    if (m_size == 2'b00) begin
                        push      = 1'b1;
                        push_byte = dbus_in[7:0];
                    end else begin
                        pack_buf_n  = dbus_in;
                        pack_idx_n  = 2'd0;
                        pack_last_n = m_size;
                        p_next      = P_PACK;
                    end
                end
            end
            P_PACK: begin
                pack_drop = wr_data;
                if (pack_cur == 8'h00) begin
                    p_next = P_IDLE;
                end else begin
                    push      = 1'b1;
                    push_byte = pack_cur;
                    if (pack_idx == pack_last) begin
                        p_next = P_IDLE;
                    end else begin
                        pack_idx_n = pack_idx + 2'd1;
                    end
                end
            end
            default: p_next = P_IDLE;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Status/control registers; a new overflow beats the read-clear
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf    <= 1'b0;
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (stat_rd_acc) begin
                ovf <= 1'b0;
            end
            if (wr_ctrl) begin
                irq_en <= dbus_in[0];
            end
            irq <= irq_en & idle;
        end
    end

    // Transmitter FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            t_state   <= T_IDLE;
            baud      <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            cur_byte  <= 8'h00;
            tx        <= 1'b1;
            tx_strobe <= 1'b0;
            tx_byte   <= 8'h00;
        end else begin
            t_state   <= t_next;
            baud      <= baud_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            cur_byte  <= cur_byte_n;
            tx        <= tx_n;
            tx_strobe <= strobe_n;
            if (strobe_n) begin
                tx_byte <= cur_byte_n;
            end
        end
    end

    // Outputs are computed from the next state so they line up with the state register
    always_comb begin
        t_next     = t_state;
        baud_n     = baud;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        cur_byte_n = cur_byte;
        pop        = 1'b0;
        tx_n       = 1'b1;
        strobe_n   = 1'b0;
        if (t_state != T_IDLE) begin
            baud_n = baud_end ? '0 : baud + BW'(1);
        end
        case (t_state)
            T_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shreg_n    = head;
                    cur_byte_n = head;
                    baud_n     = '0;
                    t_next     = T_START;
                end
            end
            T_START: begin
                if (baud_end) begin
                    bit_idx_n = 3'd0;
                    t_next    = T_DATA;
                end
            end
            T_DATA: begin
                if (baud_end) begin
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        t_next = T_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            T_STOP: begin
                if (baud_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shreg_n    = head;
                        cur_byte_n = head;
                        t_next     = T_START;
                    end else begin
                        t_next = T_IDLE;
                    end
                end
            end
            default: t_next = T_IDLE;
        endcase
        case (t_next)
            T_START: tx_n = 1'b0;
            T_DATA:  tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
        strobe_n = (t_next == T_STOP) && (baud_n == BAUD_LAST);
    end

endmodule
